// File: rtl/bcd_entry_buf_pkg.sv
// bcd_entry_buf_pkg: sign display codes, FSM state encoding and BCD limit shared by the entry buffer
`ifndef BCD_ENTRY_BUF_CODES
`define BCD_ENTRY_BUF_CODES
`define NEGATIVE 4'hA
`define OFF 4'hF
`endif
package bcd_entry_buf_pkg;
  typedef enum logic {ENTRY, FULL} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_entry_buf_if.sv
// bcd_entry_buf_if: committed-entry valid/ready channel towards the calculator datapath
interface bcd_entry_buf_if #(parameter int NDIGITS = 3) ();
  logic [4*NDIGITS-1:0] out_digits;
  logic out_neg;
  logic out_valid;
  logic out_ready;
  modport master(output out_digits, out_neg, out_valid, input out_ready);
  modport slave(input out_digits, out_neg, out_valid, output out_ready);
endinterface

// File: rtl/bcd_entry_buf_key_edge_sync.sv
// bcd_entry_buf_key_edge_sync: STAGES-flop synchroniser followed by a one-cycle rising-edge pulse
module bcd_entry_buf_key_edge_sync #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [STAGES:0] sh;
  // sh[STAGES-1] is the synchronised level, sh[STAGES] its previous value
  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= '0;
    else sh <= {sh[STAGES-1:0], d};
  assign pulse = sh[STAGES-1] & ~sh[STAGES];
endmodule

// File: rtl/bcd_entry_buf.sv
// bcd_entry_buf: BCD keypad entry buffer with backspace/clear and a one-deep committed output; BCD_ENTRY_DIGIT_CHECK_EN rejects digits above 9
module bcd_entry_buf
  import bcd_entry_buf_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_stb,
  input  logic [3:0] key_num,
  input  logic key_bksp,
  input  logic key_clr,
  input  logic sign_on,
  output logic [4*NDIGITS-1:0] entry_digits,
  output logic [$clog2(NDIGITS+1)-1:0] entry_cnt,
  output logic [NDIGITS:0] track_inp,
  output logic [3:0] sign,
  output logic sign_mode,
  output logic busy,
  output logic err,
  bcd_entry_buf_if.master ob
);
  localparam int CW = $clog2(NDIGITS + 1);
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  localparam logic [NDIGITS:0] ONE = 1;
  logic stb_ev, bksp_ev, clr_ev, complete, can_commit, digit_ok;
  logic [IW-1:0] idx, bidx;
  logic [NDIGITS-1:0][3:0] digits;
  state_t state;
  bcd_entry_buf_key_edge_sync #(.STAGES(SYNC_STAGES)) u_stb (.clk(clk), .rst(rst), .d(key_stb), .pulse(stb_ev));
  bcd_entry_buf_key_edge_sync #(.STAGES(SYNC_STAGES)) u_bksp (.clk(clk), .rst(rst), .d(key_bksp), .pulse(bksp_ev));
  bcd_entry_buf_key_edge_sync #(.STAGES(SYNC_STAGES)) u_clr (.clk(clk), .rst(rst), .d(key_clr), .pulse(clr_ev));
`ifdef BCD_ENTRY_DIGIT_CHECK_EN
  assign digit_ok = key_num <= BCD_MAX;
`else
  assign digit_ok = 1'b1;
`endif
  // a full entry sits one cycle with entry_cnt==NDIGITS before it commits or parks in FULL
  assign complete = entry_cnt == CW'(NDIGITS);
  assign can_commit = !ob.out_valid || ob.out_ready;
  assign idx = entry_cnt[IW-1:0];
  assign bidx = IW'(entry_cnt - 1'b1);
  assign entry_digits = digits;
  assign track_inp = ONE << entry_cnt;
  assign busy = state == FULL;
  // entry collection, commit into the output register and handshake bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
      entry_cnt <= '0;
      state <= ENTRY;
      err <= 1'b0;
      ob.out_digits <= '0;
      ob.out_neg <= 1'b0;
      ob.out_valid <= 1'b0;
      sign <= `OFF;
      sign_mode <= 1'b0;
    end else begin
      sign <= sign_on ? `NEGATIVE : `OFF;
      sign_mode <= sign_on;
      err <= 1'b0;
      if (ob.out_valid && ob.out_ready) ob.out_valid <= 1'b0;
      if (clr_ev) begin
        digits <= '0;
        entry_cnt <= '0;
        state <= ENTRY;
      end else if (complete) begin
        err <= stb_ev | bksp_ev;
        if (can_commit) begin
          ob.out_digits <= digits;
          ob.out_neg <= sign_mode;
          ob.out_valid <= 1'b1;
          digits <= '0;
          entry_cnt <= '0;
          state <= ENTRY;
        end else state <= FULL;
      end else if (bksp_ev) begin
        if (entry_cnt != '0) begin
          entry_cnt <= entry_cnt - 1'b1;
          digits[bidx] <= 4'd0;
        end
      end else if (stb_ev) begin
        if (digit_ok) begin
          digits[idx] <= key_num;
          entry_cnt <= entry_cnt + 1'b1;
        end else err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_entry_buf.sv
// tb_bcd_entry_buf: directed keypad sequences checked every cycle against a list-based entry model
module tb_bcd_entry_buf;
  import bcd_entry_buf_pkg::*;
  localparam int N = 3;
  localparam int S = 2;
  localparam int W = 4 * N;
`ifdef BCD_ENTRY_DIGIT_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  logic clk = 0, rst = 1, key_stb = 0, key_bksp = 0, key_clr = 0, sign_on = 0;
  logic [3:0] key_num = 0;
  logic [W-1:0] entry_digits;
  logic [$clog2(N+1)-1:0] entry_cnt;
  logic [N:0] track_inp;
  logic [3:0] sign;
  logic sign_mode, busy, err;
  int total = 0, bad = 0, errs = 0;
  bit started = 0;
  logic [W-1:0] acc_digits[$];
  bit acc_neg[$];
  int q[$];
  logic [W-1:0] m_out;
  bit m_neg, m_valid, m_full, m_err, m_sm;
  logic [15:0] hs, hb, hc;
  bcd_entry_buf_if #(.NDIGITS(N)) ob ();
  bcd_entry_buf #(.NDIGITS(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .key_stb(key_stb), .key_num(key_num), .key_bksp(key_bksp),
    .key_clr(key_clr), .sign_on(sign_on), .entry_digits(entry_digits), .entry_cnt(entry_cnt),
    .track_inp(track_inp), .sign(sign), .sign_mode(sign_mode), .busy(busy), .err(err), .ob(ob)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] pack_q();
    logic [W-1:0] v = '0;
    foreach (q[i]) v[4*i +: 4] = q[i][3:0];
    return v;
  endfunction
  // model: the entry is a list of digits; a key acts S+1 edges after its raw rise
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_out = '0; m_neg = 0; m_valid = 0; m_full = 0; m_err = 0; m_sm = 0;
      hs = '0; hb = '0; hc = '0;
    end else begin
      automatic bit es = hs[S-1] && !hs[S];
      automatic bit eb = hb[S-1] && !hb[S];
      automatic bit ec = hc[S-1] && !hc[S];
      automatic bit acc = m_valid && out_ready_now();
      automatic bit commit = 0;
      hs = {hs[14:0], key_stb}; hb = {hb[14:0], key_bksp}; hc = {hc[14:0], key_clr};
      m_err = 0;
      if (ec) begin
        q.delete(); m_full = 0;
      end else if (q.size() == N) begin
        m_err = es || eb;
        if (!m_valid || out_ready_now()) begin
          m_out = pack_q(); m_neg = m_sm; commit = 1; q.delete(); m_full = 0;
        end else m_full = 1;
      end else if (eb) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (es) begin
        if (CHECK && key_num > 9) m_err = 1;
        else q.push_back(int'(key_num));
      end
      m_valid = commit ? 1'b1 : acc ? 1'b0 : m_valid;
      m_sm = sign_on;
    end
  end
  function automatic bit out_ready_now();
    return ob.out_ready;
  endfunction
  // per-cycle comparison plus capture of accepted entries and err pulses
  always @(negedge clk) if (started) begin
    chk("entry_digits", 32'(entry_digits), 32'(pack_q()));
    chk("entry_cnt", 32'(entry_cnt), q.size());
    chk("track_inp", 32'(track_inp), 32'(1) << q.size());
    chk("out_digits", 32'(ob.out_digits), 32'(m_out));
    chk("out_neg", 32'(ob.out_neg), 32'(m_neg));
    chk("out_valid", 32'(ob.out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_full));
    chk("err", 32'(err), 32'(m_err));
    chk("sign", 32'(sign), m_sm ? 32'(`NEGATIVE) : 32'(`OFF));
    chk("sign_mode", 32'(sign_mode), 32'(m_sm));
    if (ob.out_valid && ob.out_ready) begin
      acc_digits.push_back(ob.out_digits);
      acc_neg.push_back(ob.out_neg);
    end
    if (err) errs++;
  end
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(logic [3:0] v);
    key_num = v; key_stb = 1; step(S + 2); key_stb = 0; step(2);
  endtask
  task automatic bksp();
    key_bksp = 1; step(S + 2); key_bksp = 0; step(2);
  endtask
  task automatic clr();
    key_clr = 1; step(S + 2); key_clr = 0; step(2);
  endtask
  initial begin
    int e0, a0;
    ob.out_ready = 1;
    step(3);
    chk("rst_track", 32'(track_inp), 1);
    chk("rst_sign", 32'(sign), 32'(`OFF));
    rst = 0;
    started = 1;
    step(1);
    chk("idle_cnt", 32'(entry_cnt), 0);
    chk("idle_valid", 32'(ob.out_valid), 0);
    press(5); press(2); press(7);
    chk("t1_digits", 32'(ob.out_digits), 32'h725);
    chk("t1_valid", 32'(ob.out_valid), 0);
    chk("t1_cnt", 32'(entry_cnt), 0);
    chk("t1_track", 32'(track_inp), 32'b0001);
    chk("t1_acc_n", acc_digits.size(), 1);
    chk("t1_acc", 32'(acc_digits[0]), 32'h725);
    ob.out_ready = 0;
    press(1); press(2); press(3);
    chk("t2_valid", 32'(ob.out_valid), 1);
    press(4); press(5); press(6);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_entry", 32'(entry_digits), 32'h654);
    chk("t2_held", 32'(ob.out_digits), 32'h321);
    e0 = errs;
    press(9);
    chk("t2_err", errs - e0, 1);
    ob.out_ready = 1;
    step(4);
    chk("t2_acc_n", acc_digits.size(), 3);
    chk("t2_acc1", 32'(acc_digits[1]), 32'h321);
    chk("t2_acc2", 32'(acc_digits[2]), 32'h654);
    chk("t2_busy_off", 32'(busy), 0);
    press(3); press(8); bksp();
    chk("t3_digits", 32'(entry_digits), 32'h003);
    chk("t3_cnt", 32'(entry_cnt), 1);
    chk("t3_track", 32'(track_inp), 32'b0010);
    e0 = errs;
    bksp(); bksp();
    chk("t3_cnt0", 32'(entry_cnt), 0);
    chk("t3_noerr", errs - e0, 0);
    press(1); press(2);
    a0 = acc_digits.size();
    key_num = 5; key_stb = 1; key_bksp = 1; key_clr = 1;
    step(S + 2);
    key_stb = 0; key_bksp = 0; key_clr = 0;
    step(2);
    chk("t4_cnt", 32'(entry_cnt), 0);
    chk("t4_digits", 32'(entry_digits), 0);
    chk("t4_nocommit", acc_digits.size() - a0, 0);
    sign_on = 1;
    step(1);
    chk("t5_sign", 32'(sign), 32'(`NEGATIVE));
    ob.out_ready = 0;
    press(1); press(0); press(0);
    chk("t5_digits", 32'(ob.out_digits), 32'h001);
    chk("t5_neg", 32'(ob.out_neg), 1);
    chk("t5_valid", 32'(ob.out_valid), 1);
    press(4);
    chk("t5_cnt", 32'(entry_cnt), 1);
    rst = 1;
    #2;
    chk("t5_rst_cnt", 32'(entry_cnt), 0);
    chk("t5_rst_track", 32'(track_inp), 1);
    chk("t5_rst_valid", 32'(ob.out_valid), 0);
    chk("t5_rst_out", 32'(ob.out_digits), 0);
    chk("t5_rst_sign", 32'(sign), 32'(`OFF));
    chk("t5_rst_mode", 32'(sign_mode), 0);
    step(2);
    rst = 0; sign_on = 0; ob.out_ready = 1;
    step(2);
    e0 = errs;
    press(4'hC);
`ifdef BCD_ENTRY_DIGIT_CHECK_EN
    chk("t6_cnt", 32'(entry_cnt), 0);
    chk("t6_err", errs - e0, 1);
`else
    chk("t6_cnt", 32'(entry_cnt), 1);
    chk("t6_digit", 32'(entry_digits[3:0]), 32'hC);
    chk("t6_noerr", errs - e0, 0);
`endif
    clr();
    chk("t6_clr", 32'(entry_cnt), 0);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
